// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl
//
// Interrupt controller for the SoC peripheral interrupt lines. Rising edges on
// each source are latched into pending bits, gated by an enable mask into a
// single CPU interrupt, and serviced through a claim/complete register
// interface. Completing a source emits a one-cycle clear pulse back to it;
// source 0 is the millisecond timer, whose write request restarts its period.
//
// Parameters:
//   NUM_SRC    number of interrupt sources (1..8), source 0 is the timer
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   src_irq_i  level interrupt lines from the peripherals
//   src_clr_o  registered one-cycle clear pulse per source
//   req_i      register access strobe, one cycle per access
//   we_i       1 = write, 0 = read, qualified by req_i
//   addr_i     register word select (0 PENDING, 1 ENABLE, 2 CLAIM, 3 reserved)
//   wdata_i    write data
//   rdata_o    registered read data, valid with ack_o, 0 otherwise
//   ack_o      registered access acknowledge, one cycle after req_i
//   cpu_irq_o  registered interrupt request to the core
// ----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_irq_i,
    output logic [NUM_SRC-1:0] src_clr_o,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic               cpu_irq_o
);

    typedef enum logic [1:0] {
        REG_PENDING  = 2'd0,
        REG_ENABLE   = 2'd1,
        REG_CLAIM    = 2'd2,
        REG_RESERVED = 2'd3
    } reg_addr_e;

    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] in_service_q;
    logic [NUM_SRC-1:0] enable_q;

    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] qualified;
    logic [NUM_SRC-1:0] claim_onehot;
    logic               claim_hit;
    logic [7:0]         claim_id;

    logic               read_req;
    logic               write_req;
    reg_addr_e          reg_sel;

    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] complete_mask;

    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] in_service_d;
    logic [NUM_SRC-1:0] enable_d;
    logic [31:0]        rdata_d;

    // Access decode and claim arbitration. The winner is the lowest-index
    // pending and enabled source, taken from the state before this cycle's
    // update; isolating the lowest set bit gives the one-hot directly.
    always_comb begin
        read_req     = req_i & ~we_i;
        write_req    = req_i & we_i;
        reg_sel      = reg_addr_e'(addr_i);
        src_edge     = src_irq_i & ~prev_q;
        qualified    = pending_q & enable_q;
        claim_onehot = qualified & (~qualified + 1'b1);
        claim_hit    = |qualified;
        claim_id     = 8'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (qualified[i]) begin
                claim_id = 8'(i);
            end
        end
    end

    // Per-source clear masks. A complete only acts when the written id names
    // a real source that is currently in service; anything else (including
    // ids past NUM_SRC) matches no bit and therefore produces no pulse.
    always_comb begin
        claim_mask    = '0;
        w1c_mask      = '0;
        complete_mask = '0;
        if (read_req && reg_sel == REG_CLAIM && claim_hit) begin
            claim_mask = claim_onehot;
        end
        if (write_req && reg_sel == REG_PENDING) begin
            w1c_mask = wdata_i[NUM_SRC-1:0];
        end
        if (write_req && reg_sel == REG_CLAIM) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (wdata_i[7:0] == 8'(i)) begin
                    complete_mask[i] = in_service_q[i];
                end
            end
        end
    end

    // Next-state for the source registers. An edge beats a W1C on the same
    // bit, a claim beats an edge, and edges are filtered by the in_service
    // value from before any complete in this cycle, so a completing source
    // drops a coincident edge.
    always_comb begin
        pending_d    = ((pending_q & ~w1c_mask) | (src_edge & ~in_service_q)) & ~claim_mask;
        in_service_d = (in_service_q | claim_mask) & ~complete_mask;
        enable_d     = enable_q;
        if (write_req && reg_sel == REG_ENABLE) begin
            enable_d = wdata_i[NUM_SRC-1:0];
        end
    end

    // Read data mux. Writes and reserved reads return zero with their ack.
    always_comb begin
        rdata_d = 32'd0;
        if (read_req) begin
            case (reg_sel)
                REG_PENDING:  rdata_d = {{(32 - NUM_SRC){1'b0}}, pending_q};
                REG_ENABLE:   rdata_d = {{(32 - NUM_SRC){1'b0}}, enable_q};
                REG_CLAIM:    rdata_d = claim_hit ? {1'b1, 23'd0, claim_id} : 32'd0;
                REG_RESERVED: rdata_d = 32'd0;
                default:      rdata_d = 32'd0;
            endcase
        end
    end

    // State and output registers. cpu_irq_o follows the registered pending
    // and enable, so it lags a pending or enable change by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            enable_q     <= '0;
            src_clr_o    <= '0;
            rdata_o      <= 32'd0;
            ack_o        <= 1'b0;
            cpu_irq_o    <= 1'b0;
        end else begin
            prev_q       <= src_irq_i;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            enable_q     <= enable_d;
            src_clr_o    <= complete_mask;
            rdata_o      <= rdata_d;
            ack_o        <= req_i;
            cpu_irq_o    <= |(pending_q & enable_q);
        end
    end

endmodule
